// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and parity helper for the convolutional encoder
package conv_pkg;

  localparam int         CONV_K_DEFAULT  = 3;
  localparam int         CONV_K_MIN      = 2;
  localparam int         CONV_K_MAX      = 8;
  localparam logic [2:0] CONV_G1_DEFAULT = 3'b111;
  localparam logic [2:0] CONV_G2_DEFAULT = 3'b101;

  // Generator taps line up bit-for-bit with the shift register (bit 0 = newest bit).
  // Narrower registers are zero-extended by the caller, so unused high taps drop out.
  function automatic logic parity_tap(input logic [CONV_K_MAX-1:0] sr,
                                      input logic [CONV_K_MAX-1:0] g);
    return ^(sr & g);
  endfunction

endpackage

// File: rtl/conv_parity.sv
// rtl/conv_parity.sv - AND-XOR reduction of one generator polynomial against the register
module conv_parity
  import conv_pkg::*;
#(
  parameter int         K = CONV_K_DEFAULT,
  parameter logic [K-1:0] G = CONV_G1_DEFAULT
) (
  input  logic [K-1:0] sr,
  output logic         p
);

  // Parity of the tapped register bits; purely combinational.
  always_comb begin
    p = parity_tap(CONV_K_MAX'(sr), CONV_K_MAX'(G));
  end

endmodule

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 feed-forward convolutional encoder (optional flush port: CONVENC_FLUSH_EN)
module conv_encoder
  import conv_pkg::*;
#(
  parameter int           K  = CONV_K_DEFAULT,
  parameter logic [K-1:0] G1 = CONV_G1_DEFAULT,
  parameter logic [K-1:0] G2 = CONV_G2_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data,
  input  logic         load,
  input  logic [K-1:0] seed,
`ifdef CONVENC_FLUSH_EN
  input  logic         flush,
`endif
  output logic         v1,
  output logic         v2
);

  if ((K < CONV_K_MIN) || (K > CONV_K_MAX)) begin : g_bad_k
    $error("conv_encoder: K=%0d outside legal range %0d..%0d", K, CONV_K_MIN, CONV_K_MAX);
  end
  if (G1 == '0) begin : g_bad_g1
    $error("conv_encoder: generator G1 must be nonzero");
  end
  if (G2 == '0) begin : g_bad_g2
    $error("conv_encoder: generator G2 must be nonzero");
  end

  logic [K-1:0] sr_q, sr_d;
  logic         v1_q, v1_d;
  logic         v2_q, v2_d;
  logic [K-1:0] sr_next;
  logic         shift_bit;
  logic         p1, p2;

  // Bit entering the register: data, or a forced 0 while terminating the trellis.
  always_comb begin
    shift_bit = data;
`ifdef CONVENC_FLUSH_EN
    if (flush) shift_bit = 1'b0;
`endif
    sr_next = {sr_q[K-2:0], shift_bit};
  end

  // Outputs are computed from the post-shift state so the new bit contributes immediately.
  conv_parity #(.K(K), .G(G1)) u_parity_g1 (.sr(sr_next), .p(p1));
  conv_parity #(.K(K), .G(G2)) u_parity_g2 (.sr(sr_next), .p(p2));

  // Next-state selection: a seed load overrides shifting and silences the outputs.
  always_comb begin
    sr_d = sr_next;
    v1_d = p1;
    v2_d = p2;
    if (load) begin
      sr_d = seed;
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  // State and coded-bit registers; reset clears history without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign v1 = v1_q;
  assign v2 = v2_q;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - directed self-checking bench for conv_encoder (K=3, G=7/5)
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       data;
  logic       load;
  logic [2:0] seed;
`ifdef CONVENC_FLUSH_EN
  logic       flush;
`endif
  logic       v1;
  logic       v2;

  int n_checks = 0;
  int n_fail   = 0;

  conv_encoder dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .load  (load),
    .seed  (seed),
`ifdef CONVENC_FLUSH_EN
    .flush (flush),
`endif
    .v1    (v1),
    .v2    (v2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load  = 1'b0;
    seed  = 3'b000;
    data  = 1'b0;
`ifdef CONVENC_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_initial: v1v2=%b expected 00", {v1, v2});
    end
    for (int i = 0; i < 4; i++) begin
      data = ~data;
      step();
      n_checks++;
      if ({v1, v2} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_held[%0d]: v1v2=%b expected 00", i, {v1, v2});
      end
    end
    reset = 1'b1;
    data  = 1'b1;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_first: v1v2=%b expected 11", {v1, v2});
    end
  endtask

  task automatic test_stream();
    logic       d_vec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] e_vec [4] = '{2'b11, 2'b10, 2'b00, 2'b10};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      data = d_vec[i];
      step();
      n_checks++;
      if ({v1, v2} !== e_vec[i]) begin
        n_fail++;
        $display("FAIL stream[%0d]: v1v2=%b expected %b", i, {v1, v2}, e_vec[i]);
      end
    end
  endtask

  task automatic test_load();
    apply_reset();
    data = 1'b1;
    step();
    load = 1'b1; seed = 3'b101; data = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_a_out: v1v2=%b expected 00", {v1, v2});
    end
    load = 1'b0; data = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b10) begin
      n_fail++;
      $display("FAIL load_then_0: v1v2=%b expected 10", {v1, v2});
    end
    load = 1'b1; seed = 3'b101; data = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_b_out: v1v2=%b expected 00", {v1, v2});
    end
    load = 1'b0; data = 1'b1;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b01) begin
      n_fail++;
      $display("FAIL load_then_1: v1v2=%b expected 01", {v1, v2});
    end
  endtask

  task automatic test_load_ignores_data();
    apply_reset();
    load = 1'b1; seed = 3'b101; data = 1'b1;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_data1_out: v1v2=%b expected 00", {v1, v2});
    end
    load = 1'b0; data = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b10) begin
      n_fail++;
      $display("FAIL load_data1_state: v1v2=%b expected 10", {v1, v2});
    end
  endtask

  task automatic test_load_hold();
    apply_reset();
    load = 1'b1; seed = 3'b111; data = 1'b1;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_hold_0: v1v2=%b expected 00", {v1, v2});
    end
    seed = 3'b101;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_hold_1: v1v2=%b expected 00", {v1, v2});
    end
    load = 1'b0; data = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b10) begin
      n_fail++;
      $display("FAIL load_hold_reseed: v1v2=%b expected 10", {v1, v2});
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] e_vec [3] = '{2'b11, 2'b01, 2'b10};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      data = 1'b1;
      step();
      n_checks++;
      if ({v1, v2} !== e_vec[i]) begin
        n_fail++;
        $display("FAIL ones[%0d]: v1v2=%b expected %b", i, {v1, v2}, e_vec[i]);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_async: v1v2=%b expected 00", {v1, v2});
    end
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_held: v1v2=%b expected 00", {v1, v2});
    end
    reset = 1'b1;
    data  = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_history: v1v2=%b expected 00", {v1, v2});
    end
  endtask

`ifdef CONVENC_FLUSH_EN
  task automatic test_flush();
    logic [1:0] e_vec [3] = '{2'b01, 2'b11, 2'b00};
    apply_reset();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 1'b1;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      flush = 1'b1;
      data  = 1'b1;
      step();
      n_checks++;
      if ({v1, v2} !== e_vec[i]) begin
        n_fail++;
        $display("FAIL flush[%0d]: v1v2=%b expected %b", i, {v1, v2}, e_vec[i]);
      end
    end
    flush = 1'b0; data = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_state_zero: v1v2=%b expected 00", {v1, v2});
    end
    flush = 1'b1; load = 1'b1; seed = 3'b101; data = 1'b1;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_load_prio_out: v1v2=%b expected 00", {v1, v2});
    end
    flush = 1'b0; load = 1'b0; data = 1'b0;
    step();
    n_checks++;
    if ({v1, v2} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_load_prio_state: v1v2=%b expected 10", {v1, v2});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_load();
    test_load_ignores_data();
    test_load_hold();
    test_mid_reset();
`ifdef CONVENC_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
